// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: channel mode encodings and parameter limits.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_UPDOWN = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam int MIN_CHANNELS = 1;
    localparam int MAX_CHANNELS = 16;
    localparam int MIN_WIDTH    = 2;
    localparam int MAX_WIDTH    = 32;

endpackage

// File: rtl/timer_chan.sv
// One counter channel: up, down or up-down counting on prescaler ticks,
// with start/stop control, terminal-event reload and a sticky event flag.
module timer_chan
    import timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick,
    input  logic [WIDTH-1:0] top,
    input  logic [1:0]       mode,
    input  logic             freerun,
    input  logic             start,
    input  logic             stop,
    input  logic             clr_it,
    output logic [WIDTH-1:0] cnt,
    output logic             run,
    output logic             it
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_e            chan_mode;
    logic             down_dir;
    logic [WIDTH-1:0] load;
    logic             term;
    logic             turn;

    assign chan_mode = mode_e'(mode);

    // The reserved mode falls into the default arm and behaves as up-counting.
    always_comb begin
        load = (chan_mode == MODE_DOWN) ? top : '0;
        term = 1'b0;
        turn = 1'b0;
        if (run && tick) begin
            case (chan_mode)
                MODE_DOWN: term = (cnt == '0);
                MODE_UPDOWN: begin
                    term = (top == '0) || (down_dir && (cnt == '0));
                    turn = !down_dir && !term && (cnt >= top);
                end
                default: term = (cnt >= top);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt      <= load;
            run      <= 1'b0;
            it       <= 1'b0;
            down_dir <= 1'b0;
        end else begin
            if (term)
                it <= 1'b1;
            else if (clr_it)
                it <= 1'b0;

            if (stop) begin
                run <= 1'b0;
            end else if (start) begin
                run      <= 1'b1;
                cnt      <= load;
                down_dir <= 1'b0;
            end else if (term) begin
                run      <= freerun;
                cnt      <= load;
                down_dir <= 1'b0;
            end else if (run && tick) begin
                if (turn) begin
                    down_dir <= 1'b1;
                    cnt      <= cnt - ONE;
                end else if (chan_mode == MODE_DOWN || (chan_mode == MODE_UPDOWN && down_dir)) begin
                    cnt <= cnt - ONE;
                end else begin
                    cnt <= cnt + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Bank of independent timer channels sharing one free-running prescaler,
// with a registered interrupt request from the enabled sticky flags.
module timer_bank
    import timer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int PWIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [PWIDTH-1:0]         presc,
    input  logic [CHANNELS*WIDTH-1:0] top,
    input  logic [CHANNELS*2-1:0]     mode,
    input  logic [CHANNELS-1:0]       freerun,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       clr_it,
    input  logic [CHANNELS-1:0]       it_en,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS-1:0]       run,
    output logic [CHANNELS-1:0]       it,
    output logic                      irq
);

    localparam logic [PWIDTH-1:0] PONE = PWIDTH'(1);

    logic [PWIDTH-1:0] pcnt;
    logic              tick;

    // Compare with >= so a live decrease of presc below pcnt ticks at once
    // instead of waiting for the counter to wrap.
    assign tick = (pcnt >= presc);

    always_ff @(posedge clk) begin
        if (!rstn)
            pcnt <= '0;
        else if (tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + PONE;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        timer_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk    (clk),
            .rstn   (rstn),
            .tick   (tick),
            .top    (top[i*WIDTH +: WIDTH]),
            .mode   (mode[i*2 +: 2]),
            .freerun(freerun[i]),
            .start  (start[i]),
            .stop   (stop[i]),
            .clr_it (clr_it[i]),
            .cnt    (cnt[i*WIDTH +: WIDTH]),
            .run    (run[i]),
            .it     (it[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            irq <= 1'b0;
        else
            irq <= |(it & it_en);
    end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter CHANNELS, 4, number of independent counter channels (1..16).
REQ-002 Parameter WIDTH, 16, counter/top width in bits (2..32).
REQ-003 Parameter PWIDTH, 8, shared prescaler width in bits.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rstn  input  1  reset; synchronous, active-low.
REQ-006 presc  input  PWIDTH  prescaler divide-minus-one; tick every presc+1 clk cycles.
REQ-007 top  input  CHANNELS*WIDTH  per-channel terminal value, channel i at bits [i*WIDTH +: WIDTH].
REQ-008 mode  input  CHANNELS*2  per-channel mode: 00 up, 01 down, 10 up-down, 11 reserved (treated as up).
REQ-009 freerun  input  CHANNELS  1 = reload and continue after terminal event; 0 = one-shot.
REQ-010 start  input  CHANNELS  single-cycle start/restart pulse per channel.
REQ-011 stop  input  CHANNELS  single-cycle stop pulse per channel.
REQ-012 clr_it  input  CHANNELS  single-cycle write-1-to-clear of the channel's sticky flag.
REQ-013 it_en  input  CHANNELS  per-channel interrupt enable mask.
REQ-014 cnt  output  CHANNELS*WIDTH  current count per channel, registered.
REQ-015 run  output  CHANNELS  channel running, registered.
REQ-016 it  output  CHANNELS  sticky terminal-event flags, registered.
REQ-017 irq  output  1  registered OR of (it & it_en).

Function
REQ-018 Prescaler SHALL count 0..presc and assert an internal tick in the cycle it equals presc, then wrap to 0; presc=0 gives a tick every cycle; presc is sampled live.
REQ-019 Prescaler SHALL free-run whenever out of reset, independent of channel state.
REQ-020 Per-channel load value: up 0; down top; up-down 0 with direction up.
REQ-021 start on an idle or running channel SHALL, next cycle, set run=1 and cnt=load (restart); prescaler unaffected.
REQ-022 stop SHALL clear run next cycle and hold cnt; stop wins over start in the same cycle.
REQ-023 A running channel SHALL change cnt only on tick cycles: up +1, down -1, up-down +1 or -1 per direction.
REQ-024 Terminal event (evaluated on tick, running): up cnt >= top; down cnt == 0; up-down cnt == 0 while counting down.
REQ-025 Up-down SHALL reverse to down on the tick where cnt >= top (cnt then decrements), no terminal event there.
REQ-026 On terminal event: it=1, cnt=load next cycle; freerun=1 keeps run=1, freerun=0 clears run.
REQ-027 top=0: up and up-down SHALL raise a terminal event on every tick; down SHALL as well.
REQ-028 Terminal event and clr_it in the same cycle: it SHALL remain 1 (set wins).
REQ-029 start and terminal event in the same cycle: start wins (reload, run=1), it still set.
REQ-030 top lowered below cnt while up-counting: the >= compare SHALL terminate on the next tick (no wrap through 2^WIDTH).
REQ-031 Arithmetic SHALL be modulo 2^WIDTH; no carry escapes the channel.
REQ-032 irq SHALL follow it & it_en with one cycle latency.

Reset
REQ-033 While rstn=0 at a clk edge: prescaler 0, cnt=load per current mode/top, run=0, it=0, irq=0, up-down direction=up.
REQ-034 Reset mid-count SHALL abandon the run; no terminal event is generated by reset.

Structure
REQ-035 Package timer_pkg SHALL hold mode encodings (MODE_UP, MODE_DOWN, MODE_UPDOWN) and width limits.
REQ-036 One sub-module timer_chan SHALL implement a single channel (REQ-020..031); timer_bank holds the prescaler, a generate loop of timer_chan, and irq.

Verification
REQ-037 WIDTH=8, presc=0, up, top=4, freerun=1, start -> cnt 0,1,2,3,4,0,...; it set in the cycle after cnt=4; stays until clr_it.
REQ-038 presc=2, down, top=3, freerun=0 -> cnt decrements every 3 clk, reaches 0, it=1, run=0, cnt=3 held.
REQ-039 up-down, top=3, presc=0 -> cnt 0,1,2,3,2,1,0,reload; it only at 0-while-down.
REQ-040 clr_it coincident with terminal event -> it remains 1; irq=1 only when it_en=1, one cycle after it.
REQ-041 up, top=10, cnt=7, top changed to 5 -> terminal event on next tick, cnt=0.
REQ-042 rstn=0 mid-run on all channels -> next edge run=0, it=0, irq=0, cnt=load; stop+start same cycle -> run=0.
